// File: rtl/elevator_controller_seq_if.sv
// Request bus between the button front-end (master) and the elevator
// controller (slave): request strobe, floor index and the error pulse back.
interface elevator_controller_seq_if #(
  parameter int FLOOR_W = 4
) ();
  logic               req_valid;
  logic [FLOOR_W-1:0] req_floor;
  logic               req_err;

  modport master (output req_valid, output req_floor, input req_err);
  modport slave  (input req_valid, input req_floor, output req_err);
endinterface

// File: rtl/elevator_controller_seq.sv
// Sequential SCAN elevator controller: latches floor requests into a pending
// bitmap, steps the cab one floor per TRAVEL_CYCLES and holds the doors open
// for DOOR_CYCLES. Optional macro ELEV_EMERGENCY_EN adds an emergency input
// that flushes requests and parks the cab at floor 0 with the doors open.
module elevator_controller_seq #(
  parameter int FLOORS        = 16,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  elevator_controller_seq_if.slave  req,
`ifdef ELEV_EMERGENCY_EN
  input  logic                      emergency,
`endif
  output logic [FLOOR_W-1:0]        current_floor,
  output logic [1:0]                direction,
  output logic                      door_open,
  output logic [FLOORS-1:0]         pending
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_UP   = 2'b01;
  localparam logic [1:0] ST_DOWN = 2'b10;
  localparam logic [1:0] ST_DOOR = 2'b11;

  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               last_down_q, last_down_d;
  logic [TW-1:0]      travel_q, travel_d;
  logic [DW-1:0]      door_q, door_d;
  logic [FLOORS-1:0]  pending_q, pending_d;
  logic               err_q;

  logic               in_range, accept, door_hit;
  logic [FLOORS-1:0]  set_mask, clr_mask, here_mask, step_mask;
  logic [FLOOR_W-1:0] floor_step;
  logic               arrive, above, below;
  logic [1:0]         pick_state;
  logic               pick_last_down;

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    return {{(FLOORS-1){1'b0}}, 1'b1} << f;
  endfunction

  // Request qualification: range check, door-extension detection, set mask
  always_comb begin
    in_range = {1'b0, req.req_floor} < (FLOOR_W+1)'(FLOORS);
`ifdef ELEV_EMERGENCY_EN
    accept   = req.req_valid && in_range && !emergency;
`else
    accept   = req.req_valid && in_range;
`endif
    door_hit = accept && (state_q == ST_DOOR) && (req.req_floor == floor_q);
    set_mask = (accept && !door_hit) ? onehot(req.req_floor) : '0;
  end

  // Outstanding work above and below the cab, from the registered bitmap
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending_q[i]) begin
        if (i > 32'(floor_q)) above = 1'b1;
        if (i < 32'(floor_q)) below = 1'b1;
      end
    end
  end

  // SCAN preference: keep the last direction if work remains, else reverse
  always_comb begin
    pick_state = ST_IDLE;
    if (!last_down_q) begin
      if (above)      pick_state = ST_UP;
      else if (below) pick_state = ST_DOWN;
    end else begin
      if (below)      pick_state = ST_DOWN;
      else if (above) pick_state = ST_UP;
    end
    pick_last_down = (pick_state == ST_DOWN) ? 1'b1 :
                     (pick_state == ST_UP)   ? 1'b0 : last_down_q;
  end

  // Travel step geometry
  always_comb begin
    here_mask  = onehot(floor_q);
    floor_step = (state_q == ST_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    step_mask  = onehot(floor_step);
    arrive     = (travel_q == TRAVEL_LAST);
  end

  // Next-state logic for the FSM, timers and pending bitmap
  always_comb begin
    state_d     = state_q;
    floor_d     = floor_q;
    last_down_d = last_down_q;
    travel_d    = travel_q;
    door_d      = door_q;
    clr_mask    = '0;
    case (state_q)
      ST_IDLE: begin
        if (|(pending_q & here_mask)) begin
          state_d  = ST_DOOR;
          door_d   = '0;
          clr_mask = here_mask;
        end else begin
          state_d     = pick_state;
          travel_d    = '0;
          last_down_d = pick_last_down;
        end
      end
      ST_UP, ST_DOWN: begin
        if (arrive) begin
          floor_d  = floor_step;
          travel_d = '0;
          // a request landing on the arrival floor this very edge also stops the cab
          if (|((pending_q | set_mask) & step_mask)) begin
            state_d  = ST_DOOR;
            door_d   = '0;
            clr_mask = step_mask;
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end
      default: begin
        if (door_hit) begin
          door_d = '0;
        end else if (door_q == DOOR_LAST) begin
          state_d     = pick_state;
          travel_d    = '0;
          last_down_d = pick_last_down;
        end else begin
          door_d = door_q + DW'(1);
        end
      end
    endcase
    pending_d = (pending_q | set_mask) & ~clr_mask;
`ifdef ELEV_EMERGENCY_EN
    // emergency overrides every normal decision: head for floor 0 and park there
    if (emergency) begin
      pending_d = '0;
      door_d    = '0;
      if ((state_q == ST_DOWN) && (floor_q != '0)) begin
        state_d = ST_DOWN;
        if (arrive) begin
          floor_d  = floor_step;
          travel_d = '0;
          if (floor_step == '0) state_d = ST_DOOR;
        end else begin
          floor_d  = floor_q;
          travel_d = travel_q + TW'(1);
        end
      end else if (floor_q == '0) begin
        state_d  = ST_DOOR;
        floor_d  = floor_q;
        travel_d = '0;
      end else begin
        state_d     = ST_DOWN;
        floor_d     = floor_q;
        travel_d    = '0;
        last_down_d = 1'b1;
      end
    end
`endif
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      floor_q     <= '0;
      last_down_q <= 1'b0;
      travel_q    <= '0;
      door_q      <= '0;
      pending_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      last_down_q <= last_down_d;
      travel_q    <= travel_d;
      door_q      <= door_d;
      pending_q   <= pending_d;
      err_q       <= req.req_valid && !in_range;
    end
  end

  assign current_floor = floor_q;
  assign direction     = state_q;
  assign door_open     = (state_q == ST_DOOR);
  assign pending       = pending_q;
  assign req.req_err   = err_q;

endmodule

// File: tb/tb_elevator_controller_seq.sv
// Self-checking bench for elevator_controller_seq: directed scenarios plus
// randomized traffic against a cycle-level behavioural model of the cab.
module tb_elevator_controller_seq;
  localparam int FLOORS = 16;
  localparam int FW     = 5;
  localparam int TC     = 4;
  localparam int DC     = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elevator_controller_seq_if #(.FLOOR_W(FW)) req_if ();
  logic [FW-1:0]     current_floor;
  logic [1:0]        direction;
  logic              door_open;
  logic [FLOORS-1:0] pending;
  bit                emg_drv = 1'b0;
`ifdef ELEV_EMERGENCY_EN
  logic              emergency;
  assign emergency = emg_drv;
`endif

  elevator_controller_seq #(
    .FLOORS(FLOORS), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req_if.slave),
`ifdef ELEV_EMERGENCY_EN
    .emergency(emergency),
`endif
    .current_floor(current_floor), .direction(direction),
    .door_open(door_open), .pending(pending)
  );

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: floor number, motion (+1/-1/0), doors flag and a
  // countdown of edges left in the current activity.
  bit m_pend[FLOORS];
  bit m_snap[FLOORS];
  int m_floor, m_move, m_heading, m_left;
  bit m_doors, m_err;
  int served[$];

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_floor = 0; m_move = 0; m_heading = 1; m_left = 0;
    m_doors = 1'b0; m_err = 1'b0;
    served.delete();
  endtask

  function automatic bit work_toward(int d);
    for (int i = m_floor + d; i >= 0 && i < FLOORS; i += d)
      if (m_snap[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic choose();
    if (work_toward(m_heading))       m_move = m_heading;
    else if (work_toward(-m_heading)) m_move = -m_heading;
    else                              m_move = 0;
    if (m_move != 0) begin m_heading = m_move; m_left = TC; end
  endtask

  task automatic open_doors();
    m_doors = 1'b1; m_move = 0; m_left = DC;
    served.push_back(m_floor);
  endtask

  task automatic model_edge(input bit v, input int f, input bit emg);
    bit ok, extend;
    int clear_at;
    m_snap = m_pend;
    ok = v && (f < FLOORS) && !emg;
    extend = ok && m_doors && (f == m_floor);
    clear_at = -1;
    m_err = v && (f >= FLOORS);
    if (emg) begin
      if (m_doors && m_floor == 0) m_left = DC;
      else if (m_doors) begin m_doors = 1'b0; m_move = -1; m_heading = -1; m_left = TC; end
      else if (m_move < 0 && m_floor != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_floor--;
          if (m_floor == 0) open_doors(); else m_left = TC;
        end
      end else if (m_floor == 0) open_doors();
      else begin m_move = -1; m_heading = -1; m_left = TC; end
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      return;
    end
    if (m_doors) begin
      if (extend) m_left = DC;
      else begin
        m_left--;
        if (m_left == 0) begin m_doors = 1'b0; choose(); end
      end
    end else if (m_move != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_floor += m_move;
        if (m_snap[m_floor] || (ok && f == m_floor)) begin open_doors(); clear_at = m_floor; end
        else m_left = TC;
      end
    end else if (m_snap[m_floor]) begin
      open_doors(); clear_at = m_floor;
    end else choose();
    if (ok && !extend) m_pend[f] = 1'b1;
    if (clear_at >= 0) m_pend[clear_at] = 1'b0;
  endtask

  function automatic logic [FW+FLOORS+3:0] exp_vec();
    logic [FLOORS-1:0] p;
    logic [1:0] d;
    for (int i = 0; i < FLOORS; i++) p[i] = m_pend[i];
    d = m_doors ? 2'b11 : (m_move > 0) ? 2'b01 : (m_move < 0) ? 2'b10 : 2'b00;
    return {FW'(m_floor), d, m_doors, p, m_err};
  endfunction

  function automatic logic [FW+FLOORS+3:0] got();
    return {current_floor, direction, door_open, pending, req_if.req_err};
  endfunction

  function automatic bit model_idle();
    bit any = 1'b0;
    foreach (m_pend[i]) any |= m_pend[i];
    return !m_doors && (m_move == 0) && !any;
  endfunction

  task automatic step(input bit v, input int f);
    req_if.req_valid = v;
    req_if.req_floor = FW'(f);
    @(posedge clk);
    model_edge(v, f, emg_drv);
    #1;
    req_if.req_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_if.req_valid = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_floor = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (got() !== '0) begin
      mismatched++; $display("FAIL reset_values got=%h want=0", got());
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 0);
      compared++;
      if (direction !== 2'b00 || got() !== exp_vec()) begin
        mismatched++; $display("FAIL idle_after_reset got=%h want=%h", got(), exp_vec());
      end
    end
  endtask

  task automatic test_single_up();
    apply_reset();
    step(1'b1, 3);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 0);
      compared++;
      if (got() !== exp_vec()) begin
        mismatched++; $display("FAIL single_up_model k=%0d got=%h want=%h", k, got(), exp_vec());
      end
      if (k == 1) begin
        compared++;
        if (direction !== 2'b01) begin
          mismatched++; $display("FAIL single_up_start dir=%b want=01", direction);
        end
      end
      if (k == 13) begin
        compared++;
        if ({current_floor, direction, door_open} !== {5'd3, 2'b11, 1'b1}) begin
          mismatched++; $display("FAIL single_up_arrive floor=%0d dir=%b door=%b want 3/11/1",
                                 current_floor, direction, door_open);
        end
      end
      if (k == 16) begin
        compared++;
        if (direction !== 2'b00) begin
          mismatched++; $display("FAIL single_up_close dir=%b want=00", direction);
        end
      end
    end
  endtask

  task automatic test_scan();
    int n;
    apply_reset();
    step(1'b1, 5);
    n = 0;
    while (!(current_floor == 5'd2 && direction == 2'b01) && n < 100) begin
      step(1'b0, 0); n++;
      compared++;
      if (got() !== exp_vec()) begin
        mismatched++; $display("FAIL scan_approach got=%h want=%h", got(), exp_vec());
      end
    end
    compared++;
    if (n >= 100) begin mismatched++; $display("FAIL scan_reach_floor2 timeout got=%0d want=2", current_floor); end
    step(1'b1, 1);
    step(1'b1, 5);
    n = 0;
    while (!model_idle() && n < 300) begin
      step(1'b0, 0); n++;
      compared++;
      if (got() !== exp_vec()) begin
        mismatched++; $display("FAIL scan_run got=%h want=%h", got(), exp_vec());
      end
    end
    compared++;
    if (served.size() != 2 || served[0] != 5 || served[1] != 1 || pending !== '0) begin
      mismatched++; $display("FAIL scan_order served=%p pending=%h want {5,1} and 0", served, pending);
    end
  endtask

  task automatic test_boundaries();
    int n;
    apply_reset();
    step(1'b1, 15);
    step(1'b1, 0);
    n = 0;
    while (!model_idle() && n < 400) begin
      step(1'b0, 0); n++;
      compared++;
      if (got() !== exp_vec() || current_floor > 5'd15) begin
        mismatched++; $display("FAIL bounds_run got=%h want=%h", got(), exp_vec());
      end
    end
    compared++;
    if (served.size() != 2 || served[0] != 15 || served[1] != 0 || current_floor !== 5'd0) begin
      mismatched++; $display("FAIL bounds_order served=%p floor=%0d want {15,0} floor 0", served, current_floor);
    end
    step(1'b1, 16);
    compared++;
    if (req_if.req_err !== 1'b1 || pending !== '0) begin
      mismatched++; $display("FAIL req_err_pulse err=%b pending=%h want 1 and 0", req_if.req_err, pending);
    end
    step(1'b0, 0);
    compared++;
    if (req_if.req_err !== 1'b0) begin
      mismatched++; $display("FAIL req_err_clear err=%b want=0", req_if.req_err);
    end
  endtask

  task automatic test_door_ext();
    int n;
    apply_reset();
    step(1'b1, 2);
    n = 0;
    while (door_open !== 1'b1 && n < 60) begin
      step(1'b0, 0); n++;
      compared++;
      if (got() !== exp_vec()) begin
        mismatched++; $display("FAIL door_ext_approach got=%h want=%h", got(), exp_vec());
      end
    end
    step(1'b0, 0);
    step(1'b1, 2);
    for (int k = 1; k <= DC; k++) begin
      step(1'b0, 0);
      compared++;
      if (door_open !== (k < DC) || pending !== '0 || got() !== exp_vec()) begin
        mismatched++; $display("FAIL door_ext k=%0d door=%b pending=%h want door=%b pending=0",
                               k, door_open, pending, (k < DC));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    apply_reset();
    step(1'b1, 10);
    step(1'b1, 12);
    n = 0;
    while (current_floor < 5'd3 && n < 100) begin step(1'b0, 0); n++; end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compared++;
    if (current_floor !== '0 || pending !== '0 || direction !== 2'b00 || door_open !== 1'b0) begin
      mismatched++; $display("FAIL reset_mid floor=%0d pending=%h dir=%b want 0/0/00",
                             current_floor, pending, direction);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    apply_reset();
    for (int i = 0; i < FLOORS; i++) begin
      step(1'b1, i);
      compared++;
      if (got() !== exp_vec()) begin
        mismatched++; $display("FAIL b2b_issue got=%h want=%h", got(), exp_vec());
      end
    end
    n = 0;
    while (!model_idle() && n < 800) begin
      step(1'b0, 0); n++;
      compared++;
      if (got() !== exp_vec()) begin
        mismatched++; $display("FAIL b2b_run got=%h want=%h", got(), exp_vec());
      end
    end
    compared++;
    if (served.size() != FLOORS || pending !== '0) begin
      mismatched++; $display("FAIL b2b_all_served count=%0d pending=%h want %0d and 0",
                             served.size(), pending, FLOORS);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 4) == 0, $urandom_range(0, 19));
      compared++;
      if (got() !== exp_vec()) begin
        mismatched++; $display("FAIL random k=%0d got=%h want=%h", k, got(), exp_vec());
      end
    end
  endtask

`ifdef ELEV_EMERGENCY_EN
  task automatic test_emergency();
    int n;
    apply_reset();
    step(1'b1, 9);
    n = 0;
    while (!(current_floor == 5'd6 && direction == 2'b01) && n < 100) begin step(1'b0, 0); n++; end
    emg_drv = 1'b1;
    for (int k = 0; k < 60; k++) begin
      step(1'b1, $urandom_range(0, 17));
      compared++;
      if (got() !== exp_vec() || pending !== '0) begin
        mismatched++; $display("FAIL emergency_run got=%h want=%h", got(), exp_vec());
      end
    end
    compared++;
    if (current_floor !== '0 || door_open !== 1'b1) begin
      mismatched++; $display("FAIL emergency_park floor=%0d door=%b want 0/1", current_floor, door_open);
    end
    emg_drv = 1'b0;
    for (int k = 1; k <= DC; k++) begin
      step(1'b0, 0);
      compared++;
      if (got() !== exp_vec() || door_open !== (k < DC)) begin
        mismatched++; $display("FAIL emergency_release k=%0d got=%h want=%h", k, got(), exp_vec());
      end
    end
  endtask
`endif

  initial begin
    req_if.req_valid = 1'b0;
    req_if.req_floor = '0;
    test_reset();
    test_single_up();
    test_scan();
    test_boundaries();
    test_door_ext();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef ELEV_EMERGENCY_EN
    test_emergency();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/elevator_controller_seq.md
Name: elevator_controller_seq

Overview:
- Clocked, parametrised successor to the combinational floor-to-description elevator controller.
- Latches floor requests into a pending bitmap and runs a SCAN (elevator) scheduling FSM.
- Steps the cab one floor per TRAVEL_CYCLES and holds doors open for DOOR_CYCLES.
- Sits between the request/button front-end and the cab/door actuator models in the elevator simulation.

Parameters:
- FLOORS, 16: number of floors, 2..2**FLOOR_W.
- FLOOR_W, 4: floor index width.
- TRAVEL_CYCLES, 4: clock cycles to move one floor, ≥1.
- DOOR_CYCLES, 3: clock cycles doors stay open, ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe, sampled each rising edge.
- req_floor  in  FLOOR_W  requested floor, valid with req_valid.
- req_err  out  1  one-cycle pulse: previous-edge request had req_floor ≥ FLOORS.
- current_floor  out  FLOOR_W  cab position.
- direction  out  2  00 idle, 01 moving up, 10 moving down, 11 doors open.
- door_open  out  1  high exactly while in DOOR state.
- pending  out  FLOORS  outstanding-request bitmap, bit i = floor i.

Behaviour:
- Reset is asynchronous; all state clears immediately on rst_n low, including mid-travel or mid-door.
- Reset values: current_floor=0, direction=00, door_open=0, pending=0, req_err=0, state=IDLE, last_dir=up, timers=0.
- Request acceptance: on an edge with req_valid=1 and req_floor<FLOORS, pending[req_floor] is set. Duplicate requests are idempotent.
- Out-of-range request: req_floor≥FLOORS is dropped and req_err=1 for the following cycle.
- Special case, door open: a request for current_floor while in DOOR restarts the door timer and does not set pending.
- above = any pending bit > current_floor; below = any pending bit < current_floor.
- FSM states: IDLE, UP, DOWN, DOOR. direction output is 00/01/10/11 respectively. All decisions use the registered pending, i.e. the value from the previous edge.
- IDLE:
  - pending[current_floor] set → DOOR; clear the bit.
  - else if last_dir=up: above → UP, else below → DOWN.
  - else if last_dir=down: below → DOWN, else above → UP.
  - else stay IDLE.
- UP/DOWN:
  - Travel timer counts 0..TRAVEL_CYCLES-1. On the edge where it reaches TRAVEL_CYCLES-1, current_floor ±1 and the timer resets to 0.
  - On the same arrival edge, if pending[new floor] is set or being set this edge → DOOR; clear the bit.
  - Otherwise continue in the same direction. Continuation is guaranteed because requests only add bits.
  - last_dir follows the state.
- Boundaries: current_floor never exceeds FLOORS-1 or goes below 0. An UP decision requires above, and a DOWN decision requires below.
- DOOR:
  - Door timer counts DOOR_CYCLES cycles.
  - On expiry, use the IDLE preference order: continue last_dir if work remains that way, else reverse, else IDLE.
  - A pending bit at current_floor cannot exist in DOOR, because same-floor requests extend the door instead.
- Simultaneous request and clear of the same bit on one edge: the clear wins only if the cab is servicing that floor on that edge. Otherwise the set wins.
- Latency, idle at floor f with a request for floor g>f accepted at edge t:
  - UP at edge t+1.
  - current_floor=g and DOOR at edge t+1+(g-f)·TRAVEL_CYCLES.

Optional Feature:
- Macro: ELEV_EMERGENCY_EN.
- Enabled: adds input port emergency (1 bit, after req_floor).
  - While emergency=1, pending is cleared each edge and new requests are ignored. req_err still functions.
  - The cab travels to floor 0 at normal speed. A cab in DOOR closes immediately.
  - On reaching floor 0, enters DOOR and holds door_open=1 for as long as emergency=1.
  - When emergency drops, the door timer restarts, then normal operation resumes with empty pending.
- Disabled: no emergency port; the FSM has no emergency paths.

Test Plan:
- Reset then idle: rst_n low 3 cycles → all outputs at reset values; drop rst_n, no requests → direction=00 for 20 cycles.
- Single up trip: at floor 0, request 3 at edge t → direction=01 from t+1; current_floor=3, direction=11, door_open=1 at t+13; back to 00 at t+16.
- SCAN ordering: cab moving up past floor 2, requests 1 and 5 arrive → services 5 first, then reverses down to 1; pending ends at 0.
- Boundaries: request 15 then 0 → reaches 15, then 0, without wrap. Request floor 16 with FLOORS=16, FLOOR_W=5 → req_err pulse, pending unchanged.
- Door extension / reset mid-op: request current floor during DOOR → door_open lasts DOOR_CYCLES past that request. Assert rst_n mid-travel → immediate current_floor=0, pending=0.
- With ELEV_EMERGENCY_EN: at floor 6 moving up with pending {9}, raise emergency → pending=0, descends to 0, door held open; drop emergency → IDLE after 3 cycles.
